proto_stream_decoder: RTL

Parametrised, streaming protobuf wire-format decoder; the next generation of the protobuf deserializer.
- Full varint keys (field numbers wider than 4 bits), all non-group wire types, nested messages up to MAX_DEPTH, valid/ready flow control on both sides, sticky error reporting.
- Sits between the byte-stream ingress and field consumers in the proto pipeline.

---
 rtl/proto_stream_decoder.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/proto_stream_decoder.sv
// proto_stream_decoder: streaming protobuf wire-format decoder.
//
// One byte per accepted handshake. Keys, varints, fixed32/64 and
// length-delimited fields are decoded into one-entry output beats. Listed
// length-delimited fields open nested messages, which are tracked on a stack
// of per-level remaining byte counts. Errors are sticky until reset.
//
// Optional feature macro: PROTO_ZIGZAG_EN. When defined, varint fields
// listed in ZIGZAG_FIELD_MASK are zigzag-decoded (sint) on output.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   in_data_i/valid/ready    wire-byte input stream
//   out_valid_o/ready_i      decoded beat handshake
//   out_field_o              field number
//   out_wiretype_o           wire type 0, 1, 2 or 5
//   out_value_o              value, or payload byte in [7:0] for wire type 2
//   out_last_o               last payload byte of a wire type 2 field
//   out_depth_o              nesting depth at which the beat's key was decoded
//   msg_start_o, msg_end_o   one-cycle pulses: message opened / closed
//   err_o, err_code_o        sticky error flag and code (1..5)
module proto_stream_decoder #(
    parameter int unsigned FIELD_W           = 16,
    parameter int unsigned LEN_W             = 16,
    parameter int unsigned MAX_DEPTH         = 4,
    parameter logic [31:0] MSG_FIELD_MASK    = 32'h0,
    parameter logic [31:0] ZIGZAG_FIELD_MASK = 32'h0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [7:0]         in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [FIELD_W-1:0] out_field_o,
    output logic [2:0]         out_wiretype_o,
    output logic [63:0]        out_value_o,
    output logic               out_last_o,
    output logic [3:0]         out_depth_o,
    output logic               msg_start_o,
    output logic               msg_end_o,
    output logic               err_o,
    output logic [2:0]         err_code_o
);
    // state    | meaning
    // S_KEY    | accumulating key varint (field<<3 | wiretype)
    // S_VARINT | accumulating wire type 0 value
    // S_FIX    | collecting 4 or 8 little-endian bytes
    // S_LEN    | accumulating length prefix of a wire type 2 field
    // S_BYTES  | streaming payload bytes, one beat each
    // S_ERR    | terminal; bytes accepted and discarded
    localparam logic [2:0] S_KEY    = 3'd0;
    localparam logic [2:0] S_VARINT = 3'd1;
    localparam logic [2:0] S_FIX    = 3'd2;
    localparam logic [2:0] S_LEN    = 3'd3;
    localparam logic [2:0] S_BYTES  = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

`ifdef PROTO_ZIGZAG_EN
    localparam logic ZZ_EN = 1'b1;
`else
    localparam logic ZZ_EN = 1'b0;
`endif

    logic [2:0]         state_q, state_d;
    logic [63:0]        acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [FIELD_W-1:0] field_q, field_d;
    logic [2:0]         wt_q, wt_d;
    logic [3:0]         kdep_q, kdep_d;
    logic [3:0]         depth_q, depth_d;
    logic [LEN_W-1:0]   blen_q, blen_d;
    logic [LEN_W-1:0]   rem_q [MAX_DEPTH];
    logic [LEN_W-1:0]   rem_d [MAX_DEPTH];
    logic [LEN_W-1:0]   rem_dec [MAX_DEPTH];
    logic               ms_q, ms_d, me_q, me_d, err_q, err_d;
    logic [2:0]         ec_q, ec_d;
    logic               en_q;
    logic               ov_q, olast_q;
    logic [FIELD_W-1:0] ofield_q;
    logic [2:0]         owt_q;
    logic [63:0]        oval_q;
    logic [3:0]         odep_q;

    logic               accept, fld_small, fld_msg, fld_zz, key_wide;
    logic [6:0]         vshamt;
    logic [63:0]        vacc, facc, beat_val;
    logic [FIELD_W+4:0] fpad;
    logic [LEN_W-1:0]   parent_rem;
    logic               over_parent, beat, beat_last, push, err_set;
    logic [2:0]         err_sel;
    logic [3:0]         pop_to;

    // In ERR the input is drained regardless of the output register.
    assign in_ready_o = en_q && (state_q == S_ERR || !ov_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    assign vshamt = 7'(cnt_q) * 7'd7;
    assign vacc   = acc_q | ({57'd0, in_data_i[6:0]} << vshamt);
    assign facc   = acc_q | ({56'd0, in_data_i} << {cnt_q[2:0], 3'b000});

    // Only field numbers 0..31 can be looked up in the masks.
    assign fpad      = {5'd0, field_q};
    assign fld_small = (fpad >> 5) == '0;
    assign fld_msg   = fld_small && MSG_FIELD_MASK[fpad[4:0]];
    assign fld_zz    = ZZ_EN && fld_small && ZIGZAG_FIELD_MASK[fpad[4:0]];

    // Bits 64+ of a 10-byte key are dropped by the accumulator, so check them here.
    assign key_wide = ((vacc >> (FIELD_W + 3)) != '0) ||
                      (cnt_q == 4'd9 && in_data_i[6:1] != 6'd0);

    always_comb begin
        state_d = state_q;  acc_d = acc_q;    cnt_d = cnt_q;
        field_d = field_q;  wt_d = wt_q;      kdep_d = kdep_q;
        depth_d = depth_q;  blen_d = blen_q;
        err_d = err_q;      ec_d = ec_q;      ms_d = 1'b0;  me_d = 1'b0;
        beat = 1'b0;  beat_last = 1'b0;  beat_val = vacc;  push = 1'b0;
        err_set = 1'b0;  err_sel = 3'd0;  parent_rem = '0;  pop_to = depth_q;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            rem_dec[i] = (i < int'(depth_q)) ? rem_q[i] - LEN_W'(1) : rem_q[i];
            rem_d[i]   = rem_q[i];
            if (i == int'(depth_q) - 1) parent_rem = rem_dec[i];
        end
        // Inner counts never exceed outer ones, so the lowest exhausted level
        // is the new depth.
        for (int i = MAX_DEPTH - 1; i >= 0; i--)
            if (i < int'(depth_q) && rem_dec[i] == '0) pop_to = 4'(i);
        over_parent = (depth_q != 4'd0) && (vacc > 64'(parent_rem));

        if (accept && state_q != S_ERR) begin
            for (int i = 0; i < MAX_DEPTH; i++) rem_d[i] = rem_dec[i];
            case (state_q)
                S_KEY: begin
                    if (cnt_q == 4'd10) begin
                        err_set = 1'b1; err_sel = 3'd2;
                    end else if (!in_data_i[7]) begin
                        acc_d = '0; cnt_d = '0;
                        field_d = vacc[FIELD_W+2:3]; wt_d = vacc[2:0]; kdep_d = depth_q;
                        case (vacc[2:0])
                            3'd0:       state_d = S_VARINT;
                            3'd1, 3'd5: state_d = S_FIX;
                            3'd2:       state_d = S_LEN;
                            default:    begin err_set = 1'b1; err_sel = 3'd1; end
                        endcase
                        if (!err_set && key_wide) begin err_set = 1'b1; err_sel = 3'd3; end
                    end else begin
                        acc_d = vacc; cnt_d = cnt_q + 4'd1;
                    end
                end
                S_VARINT, S_LEN: begin
                    if (cnt_q == 4'd10) begin
                        err_set = 1'b1; err_sel = 3'd2;
                    end else if (!in_data_i[7]) begin
                        acc_d = '0; cnt_d = '0; state_d = S_KEY;
                        if (state_q == S_VARINT) begin
                            beat = 1'b1;
                            beat_val = fld_zz ? ((vacc >> 1) ^ {64{vacc[0]}}) : vacc;
                        end else if (fld_msg && int'(depth_q) >= MAX_DEPTH) begin
                            err_set = 1'b1; err_sel = 3'd4;
                        end else if (over_parent) begin
                            err_set = 1'b1; err_sel = 3'd5;
                        end else if (fld_msg) begin
                            push = 1'b1;
                        end else if (vacc != 64'd0) begin
                            blen_d = vacc[LEN_W-1:0]; state_d = S_BYTES;
                        end
                    end else begin
                        acc_d = vacc; cnt_d = cnt_q + 4'd1;
                    end
                end
                S_FIX: begin
                    acc_d = facc; cnt_d = cnt_q + 4'd1;
                    if (cnt_q == ((wt_q == 3'd1) ? 4'd7 : 4'd3)) begin
                        beat = 1'b1; beat_val = facc;
                        acc_d = '0; cnt_d = '0; state_d = S_KEY;
                    end
                end
                S_BYTES: begin
                    beat = 1'b1; beat_val = {56'd0, in_data_i};
                    beat_last = (blen_q == LEN_W'(1));
                    blen_d = blen_q - LEN_W'(1);
                    if (beat_last) state_d = S_KEY;
                end
                default: state_d = S_ERR;
            endcase

            // A zero-length message opens and closes on the same byte.
            if (push) begin
                ms_d = 1'b1;
                if (vacc == 64'd0) begin
                    me_d = 1'b1;
                end else begin
                    depth_d = depth_q + 4'd1;
                    for (int i = 0; i < MAX_DEPTH; i++)
                        if (i == int'(depth_q)) rem_d[i] = vacc[LEN_W-1:0];
                end
            end
            if (pop_to != depth_q) begin
                depth_d = pop_to; me_d = 1'b1;
                // A message may only close on a field boundary.
                if (!err_set && !(state_d == S_KEY && cnt_d == 4'd0)) begin
                    err_set = 1'b1; err_sel = 3'd5;
                end
            end
            if (err_set) begin
                state_d = S_ERR; err_d = 1'b1; ec_d = err_sel;
                beat = 1'b0; ms_d = 1'b0; me_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_q <= 1'b0;  state_q <= S_KEY;  acc_q <= '0;  cnt_q <= '0;
            field_q <= '0; wt_q <= '0;  kdep_q <= '0;  depth_q <= '0;  blen_q <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) rem_q[i] <= '0;
            ms_q <= 1'b0;  me_q <= 1'b0;  err_q <= 1'b0;  ec_q <= '0;
            ov_q <= 1'b0;  ofield_q <= '0;  owt_q <= '0;  oval_q <= '0;
            olast_q <= 1'b0;  odep_q <= '0;
        end else begin
            en_q <= 1'b1;  state_q <= state_d;  acc_q <= acc_d;  cnt_q <= cnt_d;
            field_q <= field_d;  wt_q <= wt_d;  kdep_q <= kdep_d;
            depth_q <= depth_d;  blen_q <= blen_d;
            for (int i = 0; i < MAX_DEPTH; i++) rem_q[i] <= rem_d[i];
            ms_q <= ms_d;  me_q <= me_d;  err_q <= err_d;  ec_q <= ec_d;
            if (beat) begin
                ov_q <= 1'b1;  ofield_q <= field_q;  owt_q <= wt_q;
                oval_q <= beat_val;  olast_q <= beat_last;  odep_q <= kdep_q;
            end else if (out_ready_i) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign out_valid_o    = ov_q;
    assign out_field_o    = ofield_q;
    assign out_wiretype_o = owt_q;
    assign out_value_o    = oval_q;
    assign out_last_o     = olast_q;
    assign out_depth_o    = odep_q;
    assign msg_start_o    = ms_q;
    assign msg_end_o      = me_q;
    assign err_o          = err_q;
    assign err_code_o     = ec_q;
endmodule
